code_entry_controller: RTL and testbench
========================================

CODE_ENTRY_CONTROLLER -- requirements
Module: code_entry_controller

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 2, meaning digits per product code (legal 1..4).
REQ-002 SHALL have parameter OUT_W, default 7, meaning product_no width (must hold 10^NUM_DIGITS-1).
REQ-003 SHALL have parameter MAX_PRODUCT, default 63, meaning highest legal product number.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1000, meaning idle cycles before a partial entry is discarded (>=2).
REQ-005 SHALL have ports clock  in  1  system clock (all logic on rising edge).
REQ-006 SHALL have port reset_n  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port valid  in  1  one-cycle key strobe; code sampled when high.
REQ-008 SHALL have port code  in  4  key code: 0-9 digit, 0xA backspace, 0xB cancel, 0xC-0xF illegal.
REQ-009 SHALL have port product_no  out  OUT_W  last accepted product number.
REQ-010 SHALL have port valid_product  out  1  one-cycle pulse: product_no newly valid.
REQ-011 SHALL have port err_valid  out  1  one-cycle pulse: entry rejected.
REQ-012 SHALL have port err_code  out  2  0 illegal key, 1 out of range, 2 timeout; held until next error.
REQ-013 SHALL have port digit_count  out  3  digits currently entered.
REQ-014 SHALL have port S_Row  out  1  keypad row-scan enable.

Function
REQ-015 SHALL implement states IDLE (count 0), COLLECT (0<count<NUM_DIGITS), CHECK (count==NUM_DIGITS).
REQ-016 SHALL, on valid with digit d in IDLE/COLLECT: acc <= acc*10+d, count+1; to CHECK when count reaches NUM_DIGITS, else COLLECT.
REQ-017 SHALL compute acc at OUT_W bits with no truncation for legal parameter sets.
REQ-018 SHALL, in CHECK (exactly one cycle): if acc<=MAX_PRODUCT, load product_no<=acc and pulse valid_product; else pulse err_valid with err_code=1, product_no unchanged; then acc<=0, count<=0, to IDLE.
REQ-019 SHALL give latency: final digit sampled at edge k -> valid_product/err_valid high during cycle after edge k+1, for one cycle.
REQ-020 SHALL ignore valid during CHECK (no state, acc, or timer effect).
REQ-021 SHALL, on backspace: acc <= acc/10, count-1; to IDLE if count becomes 0; no effect in IDLE.
REQ-022 SHALL, on cancel: acc<=0, count<=0, to IDLE, no error pulse.
REQ-023 SHALL, on illegal key (0xC-0xF) in IDLE/COLLECT: acc<=0, count<=0, to IDLE, pulse err_valid, err_code=0.
REQ-024 SHALL run a timeout counter only in COLLECT; reset to 0 on every accepted key; on reaching TIMEOUT_CYCLES-1 with no key that cycle: clear entry, to IDLE, pulse err_valid, err_code=2.
REQ-025 SHALL give a key accepted in the same cycle as timeout expiry priority; timer restarts, no timeout error.
REQ-026 SHALL hold product_no between accepted codes; valid_product and err_valid never both high.
REQ-027 SHALL drive S_Row high every cycle after the first non-reset edge.

Reset
REQ-028 SHALL, while reset_n low at a rising edge: state IDLE, acc 0, count 0, timer 0, product_no 0, valid_product 0, err_valid 0, err_code 0, digit_count 0, S_Row 0.
REQ-029 SHALL, on reset mid-entry or during CHECK, discard the entry with no output pulse.
REQ-030 SHALL ignore valid in the cycle reset_n is low.

Verification
REQ-031 SHALL cover: defaults, keys 4,2 -> product_no=42, valid_product single pulse, 2 cycles after the edge sampling "2".
REQ-032 SHALL cover: keys 7,0 (70>63) -> err_valid pulse, err_code=1, product_no keeps prior 42.
REQ-033 SHALL cover: keys 5, 0xA, 1, 2 -> product_no=12; keys 3, 0xB -> count 0, no pulse.
REQ-034 SHALL cover: key 0xE -> err_code=0; key 3 then 1000 idle cycles -> err_code=2, count 0; key arriving on expiry cycle -> no timeout.
REQ-035 SHALL cover: NUM_DIGITS=3, OUT_W=10, MAX_PRODUCT=999, keys 9,9,9 -> product_no=999; reset_n low after first digit -> all outputs 0, next pair forms fresh code.

Source files
------------

// File: rtl/code_entry_controller.sv
// rtl/code_entry_controller.sv - keypad product-code entry controller
//
// Collects NUM_DIGITS decimal key presses into a product number, supporting
// backspace, cancel, illegal-key rejection and an inactivity timeout.
//
// Ports:
//   clock          in   system clock, all logic on the rising edge
//   reset_n        in   synchronous active-low reset
//   valid          in   one-cycle key strobe, code sampled when high
//   code[3:0]      in   0-9 digit, 0xA backspace, 0xB cancel, 0xC-0xF illegal
//   product_no     out  last accepted product number (held between codes)
//   valid_product  out  one-cycle pulse, product_no newly valid
//   err_valid      out  one-cycle pulse, entry rejected
//   err_code[1:0]  out  0 illegal key, 1 out of range, 2 timeout; held
//   digit_count    out  digits currently entered
//   S_Row          out  keypad row-scan enable, high once out of reset

module code_entry_controller #(
    parameter int NUM_DIGITS     = 2,
    parameter int OUT_W          = 7,
    parameter int MAX_PRODUCT    = 63,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             valid,
    input  logic [3:0]       code,
    output logic [OUT_W-1:0] product_no,
    output logic             valid_product,
    output logic             err_valid,
    output logic [1:0]       err_code,
    output logic [2:0]       digit_count,
    output logic             S_Row
);

    localparam int               TW         = $clog2(TIMEOUT_CYCLES);
    localparam logic [2:0]       LAST_COUNT = 3'(NUM_DIGITS);
    localparam logic [TW-1:0]    TIMER_MAX  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [OUT_W-1:0] TEN        = OUT_W'(10);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_CHECK   = 2'd2
    } state_t;

    state_t           r_state;
    logic [OUT_W-1:0] r_acc;
    logic [2:0]       r_count;
    logic [TW-1:0]    r_timer;
    logic [OUT_W-1:0] r_product;
    logic             r_valid_product;
    logic             r_err_valid;
    logic [1:0]       r_err_code;
    logic             r_srow;

    state_t           w_state_nxt;
    logic [OUT_W-1:0] w_acc_nxt;
    logic [2:0]       w_count_nxt;
    logic [TW-1:0]    w_timer_nxt;
    logic [OUT_W-1:0] w_product_nxt;
    logic             w_valid_product_nxt;
    logic             w_err_valid_nxt;
    logic [1:0]       w_err_code_nxt;

    logic             w_is_digit;
    logic             w_is_bksp;
    logic             w_is_cancel;
    logic [OUT_W-1:0] w_acc_shift;
    logic [OUT_W-1:0] w_acc_div10;
    logic [2:0]       w_count_inc;
    logic [31:0]      w_acc_wide;
    logic             w_in_range;

    assign w_is_digit  = (code <= 4'd9);
    assign w_is_bksp   = (code == 4'hA);
    assign w_is_cancel = (code == 4'hB);

    // acc*10 + d as shifts; the accumulator holds fewer than NUM_DIGITS
    // digits here, so the result always fits in OUT_W bits.
    assign w_acc_shift = (r_acc << 3) + (r_acc << 1) + OUT_W'(code);
    assign w_acc_div10 = r_acc / TEN;
    assign w_count_inc = r_count + 3'd1;
    assign w_acc_wide  = 32'(r_acc);
    assign w_in_range  = (w_acc_wide <= 32'(MAX_PRODUCT));

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state         <= ST_IDLE;
            r_acc           <= '0;
            r_count         <= '0;
            r_timer         <= '0;
            r_product       <= '0;
            r_valid_product <= 1'b0;
            r_err_valid     <= 1'b0;
            r_err_code      <= 2'd0;
            r_srow          <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_acc           <= w_acc_nxt;
            r_count         <= w_count_nxt;
            r_timer         <= w_timer_nxt;
            r_product       <= w_product_nxt;
            r_valid_product <= w_valid_product_nxt;
            r_err_valid     <= w_err_valid_nxt;
            r_err_code      <= w_err_code_nxt;
            r_srow          <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        w_acc_nxt           = r_acc;
        w_count_nxt         = r_count;
        w_timer_nxt         = r_timer;
        w_product_nxt       = r_product;
        w_valid_product_nxt = 1'b0;
        w_err_valid_nxt     = 1'b0;
        w_err_code_nxt      = r_err_code;

        case (r_state)
            ST_IDLE, ST_COLLECT: begin
                if (valid) begin
                    // Any key restarts the inactivity timer, which also gives
                    // a key priority over an expiry in the same cycle.
                    w_timer_nxt = '0;
                    if (w_is_digit) begin
                        w_acc_nxt   = w_acc_shift;
                        w_count_nxt = w_count_inc;
                        w_state_nxt = (w_count_inc == LAST_COUNT) ? ST_CHECK : ST_COLLECT;
                    end else if (w_is_bksp) begin
                        if (r_state == ST_COLLECT) begin
                            w_acc_nxt   = w_acc_div10;
                            w_count_nxt = r_count - 3'd1;
                            w_state_nxt = (r_count == 3'd1) ? ST_IDLE : ST_COLLECT;
                        end
                    end else if (w_is_cancel) begin
                        w_acc_nxt   = '0;
                        w_count_nxt = '0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_acc_nxt       = '0;
                        w_count_nxt     = '0;
                        w_state_nxt     = ST_IDLE;
                        w_err_valid_nxt = 1'b1;
                        w_err_code_nxt  = 2'd0;
                    end
                end else if (r_state == ST_COLLECT) begin
                    if (r_timer == TIMER_MAX) begin
                        w_acc_nxt       = '0;
                        w_count_nxt     = '0;
                        w_timer_nxt     = '0;
                        w_state_nxt     = ST_IDLE;
                        w_err_valid_nxt = 1'b1;
                        w_err_code_nxt  = 2'd2;
                    end else begin
                        w_timer_nxt = r_timer + TW'(1);
                    end
                end
            end

            // Single-cycle range check; keys arriving now are dropped.
            ST_CHECK: begin
                if (w_in_range) begin
                    w_product_nxt       = r_acc;
                    w_valid_product_nxt = 1'b1;
                end else begin
                    w_err_valid_nxt = 1'b1;
                    w_err_code_nxt  = 2'd1;
                end
                w_acc_nxt   = '0;
                w_count_nxt = '0;
                w_timer_nxt = '0;
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_acc_nxt   = '0;
                w_count_nxt = '0;
                w_timer_nxt = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign product_no    = r_product;
    assign valid_product = r_valid_product;
    assign err_valid     = r_err_valid;
    assign err_code      = r_err_code;
    assign digit_count   = r_count;
    assign S_Row         = r_srow;

endmodule

// File: tb/tb_code_entry_controller.sv
// tb/tb_code_entry_controller.sv - self-checking bench for code_entry_controller

module tb_code_entry_controller;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       valid;
    logic [3:0] code;

    logic [6:0] pn_a;
    logic       vp_a, ev_a, sr_a;
    logic [1:0] ec_a;
    logic [2:0] dc_a;

    logic [9:0] pn_b;
    logic       vp_b, ev_b, sr_b;
    logic [1:0] ec_b;
    logic [2:0] dc_b;

    always #5 clock = ~clock;

    code_entry_controller dut_a (
        .clock(clock), .reset_n(reset_n), .valid(valid), .code(code),
        .product_no(pn_a), .valid_product(vp_a), .err_valid(ev_a),
        .err_code(ec_a), .digit_count(dc_a), .S_Row(sr_a)
    );

    code_entry_controller #(
        .NUM_DIGITS(3), .OUT_W(10), .MAX_PRODUCT(999), .TIMEOUT_CYCLES(1000)
    ) dut_b (
        .clock(clock), .reset_n(reset_n), .valid(valid), .code(code),
        .product_no(pn_b), .valid_product(vp_b), .err_valid(ev_b),
        .err_code(ec_b), .digit_count(dc_b), .S_Row(sr_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: entry kept as a list of typed digits per instance.
    int m_nd  [2] = '{2, 3};
    int m_max [2] = '{63, 999};
    int m_tmo [2] = '{1000, 1000};
    int m_cnt [2];
    int m_dig [2][4];
    int m_chk [2];
    int m_idle[2];
    int m_prod[2];
    int m_vp  [2];
    int m_ev  [2];
    int m_ec  [2];
    int m_srow[2];

    task automatic check(input string name, input logic [31:0] act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int entry_value(input int i);
        int v;
        v = 0;
        for (int k = 0; k < m_cnt[i]; k++) v = v * 10 + m_dig[i][k];
        return v;
    endfunction

    task automatic model_step(input int i, input logic v, input logic [3:0] c, input logic rn);
        int val;
        if (!rn) begin
            m_cnt[i] = 0; m_chk[i] = 0; m_idle[i] = 0; m_prod[i] = 0;
            m_vp[i] = 0; m_ev[i] = 0; m_ec[i] = 0; m_srow[i] = 0;
            return;
        end
        m_srow[i] = 1;
        m_vp[i]   = 0;
        m_ev[i]   = 0;
        if (m_chk[i] != 0) begin
            val = entry_value(i);
            if (val <= m_max[i]) begin
                m_prod[i] = val;
                m_vp[i]   = 1;
            end else begin
                m_ev[i] = 1;
                m_ec[i] = 1;
            end
            m_cnt[i] = 0; m_chk[i] = 0; m_idle[i] = 0;
            return;
        end
        if (v) begin
            m_idle[i] = 0;
            if (c <= 4'd9) begin
                m_dig[i][m_cnt[i]] = int'(c);
                m_cnt[i]++;
                if (m_cnt[i] == m_nd[i]) m_chk[i] = 1;
            end else if (c == 4'hA) begin
                if (m_cnt[i] > 0) m_cnt[i]--;
            end else if (c == 4'hB) begin
                m_cnt[i] = 0;
            end else begin
                m_cnt[i] = 0;
                m_ev[i]  = 1;
                m_ec[i]  = 0;
            end
        end else if (m_cnt[i] > 0) begin
            m_idle[i]++;
            if (m_idle[i] == m_tmo[i]) begin
                m_cnt[i] = 0; m_idle[i] = 0;
                m_ev[i]  = 1; m_ec[i]  = 2;
            end
        end
    endtask

    task automatic compare_all();
        check("a.product_no",    pn_a, m_prod[0]);
        check("a.valid_product", vp_a, m_vp[0]);
        check("a.err_valid",     ev_a, m_ev[0]);
        check("a.err_code",      ec_a, m_ec[0]);
        check("a.digit_count",   dc_a, m_cnt[0]);
        check("a.S_Row",         sr_a, m_srow[0]);
        check("b.product_no",    pn_b, m_prod[1]);
        check("b.valid_product", vp_b, m_vp[1]);
        check("b.err_valid",     ev_b, m_ev[1]);
        check("b.err_code",      ec_b, m_ec[1]);
        check("b.digit_count",   dc_b, m_cnt[1]);
        check("b.S_Row",         sr_b, m_srow[1]);
    endtask

    // Called at a falling edge: drive, advance model, cross one rising edge,
    // then compare at the next falling edge.
    task automatic step(input logic v, input logic [3:0] c, input logic rn);
        reset_n = rn;
        valid   = v;
        code    = c;
        model_step(0, v, c, rn);
        model_step(1, v, c, rn);
        @(posedge clock);
        @(negedge clock);
        compare_all();
    endtask

    task automatic key(input logic [3:0] c);
        step(1'b1, c, 1'b1);
    endtask

    task automatic idle_n(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 4'd0, 1'b1);
    endtask

    task automatic clear_both();
        key(4'hB);
        idle_n(1);
    endtask

    initial begin
        int r;
        int kc;
        reset_n = 1'b0;
        valid   = 1'b0;
        code    = 4'd0;
        @(negedge clock);

        // Reset state
        step(1'b0, 4'd0, 1'b0);
        step(1'b0, 4'd0, 1'b0);
        check("lit.reset_pn_a", pn_a, 0);
        check("lit.reset_dc_a", dc_a, 0);
        check("lit.reset_srow", sr_a, 0);
        idle_n(1);
        check("lit.srow_high", sr_a, 1);

        // 4,2 -> 42, pulse two cycles after the edge sampling "2"
        key(4'd4);
        key(4'd2);
        check("lit.42_no_pulse_yet", vp_a, 0);
        check("lit.42_count", dc_a, 2);
        idle_n(1);
        check("lit.42_pulse", vp_a, 1);
        check("lit.42_value", pn_a, 42);
        idle_n(1);
        check("lit.42_single_pulse", vp_a, 0);

        // 7,0 -> out of range, product_no holds 42
        clear_both();
        key(4'd7);
        key(4'd0);
        idle_n(1);
        check("lit.70_err", ev_a, 1);
        check("lit.70_code", ec_a, 1);
        check("lit.70_hold", pn_a, 42);
        check("lit.70_no_vp", vp_a, 0);

        // 5, backspace, 1, 2 -> 12 ; 3, cancel -> count 0, no pulse
        clear_both();
        key(4'd5); key(4'hA); key(4'd1); key(4'd2);
        idle_n(1);
        check("lit.12_value", pn_a, 12);
        clear_both();
        key(4'd3);
        key(4'hB);
        check("lit.cancel_count", dc_a, 0);
        check("lit.cancel_no_err", ev_a, 0);

        // Illegal key
        clear_both();
        key(4'hE);
        check("lit.illegal_err", ev_a, 1);
        check("lit.illegal_code", ec_a, 0);

        // Timeout after 1000 idle cycles
        clear_both();
        key(4'd3);
        idle_n(999);
        check("lit.tmo_not_yet", ev_a, 0);
        idle_n(1);
        check("lit.tmo_err", ev_a, 1);
        check("lit.tmo_code", ec_a, 2);
        check("lit.tmo_count", dc_a, 0);

        // Key on the expiry cycle wins
        clear_both();
        key(4'd3);
        idle_n(999);
        key(4'd4);
        check("lit.expiry_key_no_err", ev_a, 0);
        idle_n(1);
        check("lit.expiry_key_value", pn_a, 34);

        // Three-digit instance: 9,9,9 -> 999
        clear_both();
        key(4'd9); key(4'd9); key(4'd9);
        idle_n(1);
        check("lit.999_pulse", vp_b, 1);
        check("lit.999_value", pn_b, 999);

        // Reset after first digit (valid high during reset is ignored)
        clear_both();
        key(4'd1);
        step(1'b1, 4'd5, 1'b0);
        check("lit.rst_pn_b", pn_b, 0);
        check("lit.rst_dc_b", dc_b, 0);
        check("lit.rst_srow_b", sr_b, 0);
        check("lit.rst_dc_a", dc_a, 0);
        key(4'd5); key(4'd6);
        idle_n(1);
        check("lit.fresh_56", pn_a, 56);
        key(4'd7);
        idle_n(1);
        check("lit.fresh_567", pn_b, 567);

        // Reset while in the check cycle: no pulse
        clear_both();
        key(4'd1); key(4'd2);
        step(1'b0, 4'd0, 1'b0);
        check("lit.rst_check_no_vp", vp_a, 0);
        check("lit.rst_check_no_ev", ev_a, 0);
        idle_n(1);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            r = $urandom_range(0, 399);
            if (r < 6) begin
                step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b0);
            end else if (r < 7) begin
                idle_n($urandom_range(995, 1005));
            end else if (r < 167) begin
                kc = $urandom_range(0, 19);
                if (kc < 12)      key(4'(kc % 10));
                else if (kc < 15) key(4'hA);
                else if (kc < 17) key(4'hB);
                else              key(4'(12 + $urandom_range(0, 3)));
            end else begin
                idle_n(1);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
